gcd_req_driver: RTL and testbench

//  Initiator/checker for the GCD unit's val/rdy interface. On start it issues num_req

---
 rtl/gcd_req_driver.sv | 177 +++++++++++++++++
 tb/tb_gcd_req_driver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_req_driver.sv
// gcd_req_driver: LFSR-driven val/rdy request initiator and result checker for a GCD responder
//
// Issues num_req_i operand pairs (two 16-bit LFSRs seeded from seed_i / ~seed_i),
// one outstanding request at a time, accumulates a wrapping checksum of the results
// and flags any result that cannot be a GCD of its operands.
//
// Ports:
//   clk_i        clock, rising edge
//   reset_n_i    asynchronous active-low reset
//   start_i      1-cycle start pulse, honoured only in IDLE or DONE
//   num_req_i    number of requests to issue, sampled at start
//   seed_i       LFSR seed, sampled at start
//   busy_o       high while sending/waiting
//   done_o       high in DONE
//   error_o      sticky: some result failed the sanity check
//   timeout_o    sticky: a handshake stalled past the limit
//   checksum_o   sum of accepted results mod 2^W
//   req_val_o    request valid
//   req_rdy_i    responder ready for request
//   req_a_o      operand A
//   req_b_o      operand B
//   resp_val_i   result valid
//   resp_rdy_o   driver ready for result
//   resp_data_i  GCD result
module gcd_req_driver #(
    parameter int W     = 16,
    parameter int CNT_W = 16,
    parameter int TO_W  = 12
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_req_i,
    input  logic [W-1:0]     seed_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic             timeout_o,
    output logic [W-1:0]     checksum_o,
    output logic             req_val_o,
    input  logic             req_rdy_i,
    output logic [W-1:0]     req_a_o,
    output logic [W-1:0]     req_b_o,
    input  logic             resp_val_i,
    output logic             resp_rdy_o,
    input  logic [W-1:0]     resp_data_i
);

    // The LFSR taps are fixed for a 16-bit register.
    if (W != 16) begin : g_bad_w
        $error("gcd_req_driver: W must be 16");
    end

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_e;

    // The limit is reached on the cycle whose count would become 2^TO_W-1.
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    state_e           state_q, state_d;
    logic [W-1:0]     lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [CNT_W-1:0] num_q, num_d, cnt_q, cnt_d;
    logic [TO_W-1:0]  tcnt_q, tcnt_d;
    logic             err_q, err_d, to_q, to_d;

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic bad_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] r);
        logic [W-1:0] mn;
        mn = (a < b) ? a : b;
        return (a == '0 && r != b) || (b == '0 && r != a) ||
               (a != '0 && b != '0 && (r == '0 || r > mn));
    endfunction

    always_comb begin
        state_d  = state_q;
        lfsr_a_d = lfsr_a_q;
        lfsr_b_d = lfsr_b_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        num_d    = num_q;
        cnt_d    = cnt_q;
        tcnt_d   = tcnt_q;
        err_d    = err_q;
        to_d     = to_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    // An all-zero LFSR would lock up, so zero loads become 1.
                    lfsr_a_d = (seed_i == '0) ? W'(1) : seed_i;
                    lfsr_b_d = (seed_i == '1) ? W'(1) : ~seed_i;
                    num_d    = num_req_i;
                    sum_d    = '0;
                    cnt_d    = '0;
                    tcnt_d   = '0;
                    err_d    = 1'b0;
                    to_d     = 1'b0;
                    state_d  = (num_req_i == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (req_rdy_i) begin
                    a_d      = lfsr_a_q;
                    b_d      = lfsr_b_q;
                    lfsr_a_d = lfsr_step(lfsr_a_q);
                    lfsr_b_d = lfsr_step(lfsr_b_q);
                    tcnt_d   = '0;
                    state_d  = WAIT;
                end else if (tcnt_q == TO_LAST) begin
                    to_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            WAIT: begin
                if (resp_val_i) begin
                    sum_d   = sum_q + resp_data_i;
                    cnt_d   = cnt_q + CNT_W'(1);
                    err_d   = err_q | bad_result(a_q, b_q, resp_data_i);
                    tcnt_d  = '0;
                    state_d = (cnt_q + CNT_W'(1) == num_q) ? DONE : SEND;
                end else if (tcnt_q == TO_LAST) begin
                    to_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            lfsr_a_q <= W'(1);
            lfsr_b_q <= W'(1);
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            num_q    <= '0;
            cnt_q    <= '0;
            tcnt_q   <= '0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_a_q <= lfsr_a_d;
            lfsr_b_q <= lfsr_b_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            num_q    <= num_d;
            cnt_q    <= cnt_d;
            tcnt_q   <= tcnt_d;
            err_q    <= err_d;
            to_q     <= to_d;
        end
    end

    assign busy_o     = (state_q == SEND) || (state_q == WAIT);
    assign done_o     = state_q == DONE;
    assign error_o    = err_q;
    assign timeout_o  = to_q;
    assign checksum_o = sum_q;
    assign req_val_o  = state_q == SEND;
    assign resp_rdy_o = state_q == WAIT;
    assign req_a_o    = req_val_o ? lfsr_a_q : '0;
    assign req_b_o    = req_val_o ? lfsr_b_q : '0;

endmodule

// File: tb/tb_gcd_req_driver.sv
// tb_gcd_req_driver: randomized responder bench with a behavioural reference model
module tb_gcd_req_driver;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_req = '0;
    logic [15:0] seed = '0;
    logic        busy, done, err, tmo, req_val, resp_rdy;
    logic [15:0] checksum, req_a, req_b;
    logic        req_rdy = 1'b0;
    logic        resp_val = 1'b0;
    logic [15:0] resp_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gcd_req_driver dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .num_req_i(num_req),
        .seed_i(seed), .busy_o(busy), .done_o(done), .error_o(err), .timeout_o(tmo),
        .checksum_o(checksum), .req_val_o(req_val), .req_rdy_i(req_rdy),
        .req_a_o(req_a), .req_b_o(req_b), .resp_val_i(resp_val), .resp_rdy_o(resp_rdy),
        .resp_data_i(resp_data)
    );

    function automatic logic [15:0] ref_lfsr(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x = a, y = b, t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic ref_bad(input logic [15:0] a, input logic [15:0] b,
                                     input logic [15:0] r);
        if (a == 0) return r != b;
        if (b == 0) return r != a;
        return r == 0 || r > ((a < b) ? a : b);
    endfunction

    task automatic do_start(input logic [15:0] s, input logic [15:0] n);
        @(negedge clk);
        start = 1'b1;
        seed = s;
        num_req = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: correct gcd, 1: always 0, 2: occasionally random
    task automatic run_session(input string name, input logic [15:0] s, input int n,
                               input int stall_min, input int stall_max, input int mode);
        logic [15:0] la, lb, r, exp_sum;
        logic exp_err;
        int w;
        la = (s == 16'h0000) ? 16'h0001 : s;
        lb = (s == 16'hFFFF) ? 16'h0001 : ~s;
        exp_sum = 0;
        exp_err = 0;
        do_start(s, 16'(n));
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (!req_val && w < 20) begin
                @(negedge clk);
                w++;
            end
            checks++;
            if (w != 0 || req_a !== la || req_b !== lb) begin
                failures++;
                $display("FAIL %s req%0d: waited=%0d A=%h B=%h, required waited=0 A=%h B=%h",
                         name, i, w, req_a, req_b, la, lb);
                if (!req_val) return;
            end
            repeat ($urandom_range(stall_max, stall_min)) begin
                @(negedge clk);
                checks++;
                if (req_val !== 1'b1 || req_a !== la || req_b !== lb) begin
                    failures++;
                    $display("FAIL %s stall%0d: val=%b A=%h B=%h, required val=1 A=%h B=%h",
                             name, i, req_val, req_a, req_b, la, lb);
                end
            end
            req_rdy = 1'b1;
            @(negedge clk);
            req_rdy = 1'b0;
            checks++;
            if (req_val !== 1'b0 || resp_rdy !== 1'b1 || busy !== 1'b1) begin
                failures++;
                $display("FAIL %s wait%0d: val=%b resp_rdy=%b busy=%b, required 0 1 1",
                         name, i, req_val, resp_rdy, busy);
            end
            r = ref_gcd(la, lb);
            if (mode == 1) r = 0;
            if (mode == 2 && $urandom_range(3, 0) == 0) r = 16'($urandom);
            repeat ($urandom_range(2, 0)) @(negedge clk);
            resp_val = 1'b1;
            resp_data = r;
            @(negedge clk);
            resp_val = 1'b0;
            exp_sum += r;
            exp_err |= ref_bad(la, lb, r);
            la = ref_lfsr(la);
            lb = ref_lfsr(lb);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || checksum !== exp_sum || err !== exp_err ||
            tmo !== 1'b0) begin
            failures++;
            $display("FAIL %s end: done=%b busy=%b sum=%h err=%b to=%b, required 1 0 %h %b 0",
                     name, done, busy, checksum, err, tmo, exp_sum, exp_err);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({busy, done, err, tmo, req_val, resp_rdy} !== 6'b0 || checksum !== 0 ||
            req_a !== 0 || req_b !== 0) begin
            failures++;
            $display("FAIL reset: flags=%b sum=%h A=%h B=%h, required all 0",
                     {busy, done, err, tmo, req_val, resp_rdy}, checksum, req_a, req_b);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_num_zero;
        logic seen = 0;
        do_start(16'h1234, 16'h0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL num_zero: done=%b busy=%b, required 1 0", done, busy);
        end
        seen = req_val;
        repeat (3) begin
            @(negedge clk);
            seen |= req_val;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL num_zero_val: req_val seen=%b, required 0", seen);
        end
    endtask

    task automatic test_timeout(input string name, input bit accept_first, input int exp_busy);
        int c = 0;
        do_start(16'($urandom), 16'd3);
        if (accept_first) begin
            req_rdy = 1'b1;
            @(negedge clk);
            req_rdy = 1'b0;
            c = 1;
        end
        while (busy && c < 5000) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (c != exp_busy || tmo !== 1'b1 || done !== 1'b1 || req_val !== 1'b0 ||
            resp_rdy !== 1'b0) begin
            failures++;
            $display("FAIL %s: busy_cycles=%0d to=%b done=%b val=%b rdy=%b, required %0d 1 1 0 0",
                     name, c, tmo, done, req_val, resp_rdy, exp_busy);
        end
        resp_val = 1'b1;
        resp_data = 16'h5A5A;
        @(negedge clk);
        resp_val = 1'b0;
        checks++;
        if (checksum !== 16'h0 || done !== 1'b1) begin
            failures++;
            $display("FAIL %s_late: sum=%h done=%b, required 0000 1", name, checksum, done);
        end
    endtask

    task automatic test_reset_mid_wait;
        do_start(16'h0001, 16'd2);
        req_rdy = 1'b1;
        @(negedge clk);
        req_rdy = 1'b0;
        resp_val = 1'b1;
        resp_data = 16'hFFFF;
        @(negedge clk);
        resp_val = 1'b0;
        req_rdy = 1'b1;
        @(negedge clk);
        req_rdy = 1'b0;
        checks++;
        if (err !== 1'b1 || checksum !== 16'hFFFF || resp_rdy !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: err=%b sum=%h rdy=%b, required 1 ffff 1",
                     err, checksum, resp_rdy);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, tmo, req_val, resp_rdy} !== 6'b0 || checksum !== 0 ||
            req_a !== 0 || req_b !== 0) begin
            failures++;
            $display("FAIL async_reset: flags=%b sum=%h A=%h B=%h, required all 0",
                     {busy, done, err, tmo, req_val, resp_rdy}, checksum, req_a, req_b);
        end
        @(negedge clk);
        reset_n = 1'b1;
        do_start(16'hFFFF, 16'd1);
        checks++;
        if (req_val !== 1'b1 || req_a !== 16'hFFFF || req_b !== 16'h0001) begin
            failures++;
            $display("FAIL seed_ffff: val=%b A=%h B=%h, required 1 ffff 0001",
                     req_val, req_a, req_b);
        end
        req_rdy = 1'b1;
        @(negedge clk);
        req_rdy = 1'b0;
        resp_val = 1'b1;
        resp_data = 16'h0001;
        @(negedge clk);
        resp_val = 1'b0;
    endtask

    initial begin
        test_reset();
        run_session("t1_basic", 16'h0001, 1, 0, 0, 0);
        run_session("t2_zero_resp", 16'h0001, 1, 0, 0, 1);
        test_num_zero();
        run_session("t4_stall", 16'h0001, 2, 5, 5, 0);
        test_timeout("t5_send_timeout", 1'b0, 4095);
        test_timeout("wait_timeout", 1'b1, 4096);
        test_reset_mid_wait();
        run_session("seed_zero", 16'h0000, 3, 0, 2, 0);
        for (int k = 0; k < 8; k++)
            run_session($sformatf("rand%0d", k), 16'($urandom), $urandom_range(6, 1), 0, 3, 2);
        run_session("back_to_back", 16'($urandom), 5, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
